// File: rtl/dual_issue_sched_pkg.sv
// Shared definitions for the dual-issue scheduler: register-file geometry,
// scheduler state encoding and default timing parameters.
package dual_issue_sched_pkg;

    localparam int REG_ADDR_BUS   = 5;
    localparam int REG_NUM        = 32;
    localparam int DIV_LAT_DEF    = 8;
    localparam int FLUSH_HOLD_DEF = 2;
    localparam int SB_SRC_PORTS   = 4;
    localparam int SB_DST_PORTS   = 2;

    typedef logic [REG_ADDR_BUS-1:0] reg_addr_t;

    typedef enum logic {
        SCHED_RUN   = 1'b0,
        SCHED_FLUSH = 1'b1
    } sched_state_t;

    // r0 is hardwired, so a match on it never creates a dependency
    function automatic logic addr_match(input logic en, input reg_addr_t a, input reg_addr_t b);
        return en && (a == b) && (b != '0);
    endfunction

endpackage

// File: rtl/sched_scoreboard.sv
// Busy bit per architectural register for results still owed by long-latency units,
// with one writeback clear port, per-slot set ports and combinational hazard lookups.
module sched_scoreboard
    import dual_issue_sched_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  clr_valid,
    input  logic [REG_ADDR_BUS-1:0]               clr_addr,
    input  logic [SB_DST_PORTS-1:0]               set_valid,
    input  logic [SB_DST_PORTS-1:0][REG_ADDR_BUS-1:0] set_addr,
    input  logic [SB_SRC_PORTS-1:0][REG_ADDR_BUS-1:0] src_addr,
    output logic [SB_SRC_PORTS-1:0]               src_busy,
    input  logic [SB_DST_PORTS-1:0][REG_ADDR_BUS-1:0] dst_addr,
    output logic [SB_DST_PORTS-1:0]               dst_busy,
    output logic [REG_NUM-1:0]                    busy_mask
);

    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;
    logic [REG_NUM-1:0] set_vec;
    logic [REG_NUM-1:0] clr_vec;

    // Applying sets after clears lets a newly issued writer win over a same-cycle writeback
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (clr_valid) clr_vec[clr_addr] = 1'b1;
        for (int i = 0; i < SB_DST_PORTS; i++) begin
            if (set_valid[i]) set_vec[set_addr[i]] = 1'b1;
        end
        busy_d = ((busy_q & ~clr_vec) | set_vec) & {{(REG_NUM-1){1'b1}}, 1'b0};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    always_comb begin
        src_busy = '0;
        dst_busy = '0;
        for (int i = 0; i < SB_SRC_PORTS; i++) src_busy[i] = busy_q[src_addr[i]];
        for (int i = 0; i < SB_DST_PORTS; i++) dst_busy[i] = busy_q[dst_addr[i]];
    end

    assign busy_mask = busy_q;

endmodule

// File: rtl/dual_issue_sched.sv
// Decides each cycle whether slot A, both slots, or neither issue, tracking
// long-latency writers, the non-pipelined divider and the post-flush bubble.
module dual_issue_sched
    import dual_issue_sched_pkg::*;
#(
    parameter int DIV_LAT    = DIV_LAT_DEF,
    parameter int FLUSH_HOLD = FLUSH_HOLD_DEF,
    parameter int PERF_W     = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    flush,
    input  logic                    ex_ready,
    input  logic                    a_valid,
    input  logic [REG_ADDR_BUS-1:0] a_ra1,
    input  logic [REG_ADDR_BUS-1:0] a_ra2,
    input  logic [REG_ADDR_BUS-1:0] a_wa,
    input  logic                    a_re1,
    input  logic                    a_re2,
    input  logic                    a_we,
    input  logic                    a_long,
    input  logic                    a_mem,
    input  logic                    a_div,
    input  logic                    a_br,
    input  logic                    b_valid,
    input  logic [REG_ADDR_BUS-1:0] b_ra1,
    input  logic [REG_ADDR_BUS-1:0] b_ra2,
    input  logic [REG_ADDR_BUS-1:0] b_wa,
    input  logic                    b_re1,
    input  logic                    b_re2,
    input  logic                    b_we,
    input  logic                    b_long,
    input  logic                    b_mem,
    input  logic                    b_div,
    input  logic                    b_br,
    input  logic                    wb_valid,
    input  logic [REG_ADDR_BUS-1:0] wb_wa,
    output logic                    issue_a,
    output logic                    issue_b,
    output logic [REG_NUM-1:0]      busy_mask,
    output logic                    div_busy,
    output logic                    sched_state,
    output logic [PERF_W-1:0]       perf_dual,
    output logic [PERF_W-1:0]       perf_stall
);

    localparam int DIV_CW  = $clog2(DIV_LAT);
    localparam int HOLD_CW = $clog2(FLUSH_HOLD + 1);
    localparam logic [DIV_CW-1:0]  DIV_LOAD  = DIV_CW'(DIV_LAT - 2);
    localparam logic [HOLD_CW-1:0] HOLD_LOAD = HOLD_CW'(FLUSH_HOLD - 1);

    sched_state_t         state_q, state_d;
    logic [HOLD_CW-1:0]   hold_q, hold_d;
    logic [DIV_CW-1:0]    div_cnt;
    logic [SB_SRC_PORTS-1:0] src_busy;
    logic [SB_DST_PORTS-1:0] dst_busy;
    logic a_haz, b_haz, pair_raw, pair_waw, br_pair_ok;

    sched_scoreboard u_scoreboard (
        .clk       (clk),
        .resetn    (resetn),
        .clr_valid (wb_valid),
        .clr_addr  (wb_wa),
        .set_valid ({issue_b & b_we & b_long, issue_a & a_we & a_long}),
        .set_addr  ({b_wa, a_wa}),
        .src_addr  ({b_ra2, b_ra1, a_ra2, a_ra1}),
        .src_busy  (src_busy),
        .dst_addr  ({b_wa, a_wa}),
        .dst_busy  (dst_busy),
        .busy_mask (busy_mask)
    );

    assign a_haz = (a_re1 & src_busy[0]) | (a_re2 & src_busy[1]) | (a_we & dst_busy[0]);
    assign b_haz = (b_re1 & src_busy[2]) | (b_re2 & src_busy[3]) | (b_we & dst_busy[1]);
    assign pair_raw = a_we & (addr_match(b_re1, b_ra1, a_wa) | addr_match(b_re2, b_ra2, a_wa));
    assign pair_waw = b_we & addr_match(a_we, b_wa, a_wa);
    // A branch in A takes B along as its delay slot
    assign br_pair_ok = !a_br | b_valid;

    assign issue_a = a_valid & ex_ready & (state_q == SCHED_RUN) & !flush & !a_haz
                   & !(a_div & div_busy);
    assign issue_b = issue_a & b_valid & !b_haz & !pair_raw & !pair_waw
                   & !(a_mem & b_mem) & !b_div & !b_br & br_pair_ok;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            SCHED_RUN: begin
                if (flush) begin
                    state_d = SCHED_FLUSH;
                    hold_d  = HOLD_LOAD;
                end
            end
            SCHED_FLUSH: begin
                if (flush)             hold_d  = HOLD_LOAD;
                else if (hold_q == '0) state_d = SCHED_RUN;
                else                   hold_d  = hold_q - HOLD_CW'(1);
            end
            default: state_d = SCHED_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= SCHED_RUN;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // div_cnt counts the busy cycles still left after the current one
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt  <= '0;
            div_busy <= 1'b0;
        end else if (issue_a && a_div) begin
            div_cnt  <= DIV_LOAD;
            div_busy <= 1'b1;
        end else if (div_busy) begin
            if (div_cnt == '0) div_busy <= 1'b0;
            else               div_cnt  <= div_cnt - DIV_CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_dual  <= '0;
            perf_stall <= '0;
        end else begin
            perf_dual  <= perf_dual + PERF_W'(issue_a & issue_b);
            perf_stall <= perf_stall + PERF_W'(a_valid & !issue_a);
        end
    end

    assign sched_state = state_q;

endmodule

// File: tb/tb_dual_issue_sched.sv
// Directed bench for dual_issue_sched: expected issue decisions are queued when a
// step is driven and compared when the cycle's combinational outputs settle.
module tb_dual_issue_sched;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b1;
    logic        a_valid, a_re1, a_re2, a_we, a_long, a_mem, a_div, a_br;
    logic        b_valid, b_re1, b_re2, b_we, b_long, b_mem, b_div, b_br;
    logic [4:0]  a_ra1, a_ra2, a_wa, b_ra1, b_ra2, b_wa;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_wa = '0;
    logic        issue_a, issue_b, div_busy, sched_state;
    logic [31:0] busy_mask, perf_dual, perf_stall;

    int checks = 0;
    int errors = 0;
    int exp_dual = 0;
    int exp_stall = 0;

    typedef struct {
        string tag;
        logic  ia;
        logic  ib;
    } exp_t;
    exp_t expq[$];

    always #5 clk = ~clk;

    dual_issue_sched #(.DIV_LAT(8), .FLUSH_HOLD(2), .PERF_W(32)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .ex_ready(ex_ready),
        .a_valid(a_valid), .a_ra1(a_ra1), .a_ra2(a_ra2), .a_wa(a_wa),
        .a_re1(a_re1), .a_re2(a_re2), .a_we(a_we), .a_long(a_long),
        .a_mem(a_mem), .a_div(a_div), .a_br(a_br),
        .b_valid(b_valid), .b_ra1(b_ra1), .b_ra2(b_ra2), .b_wa(b_wa),
        .b_re1(b_re1), .b_re2(b_re2), .b_we(b_we), .b_long(b_long),
        .b_mem(b_mem), .b_div(b_div), .b_br(b_br),
        .wb_valid(wb_valid), .wb_wa(wb_wa),
        .issue_a(issue_a), .issue_b(issue_b), .busy_mask(busy_mask),
        .div_busy(div_busy), .sched_state(sched_state),
        .perf_dual(perf_dual), .perf_stall(perf_stall)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setA(input logic v, input logic [4:0] r1, r2, w,
                        input logic we, lng, mem, dv, br);
        a_valid = v; a_ra1 = r1; a_re1 = 1'b1; a_ra2 = r2; a_re2 = 1'b1;
        a_wa = w; a_we = we; a_long = lng; a_mem = mem; a_div = dv; a_br = br;
    endtask

    task automatic setB(input logic v, input logic [4:0] r1, r2, w,
                        input logic we, lng, mem, dv, br);
        b_valid = v; b_ra1 = r1; b_re1 = 1'b1; b_ra2 = r2; b_re2 = 1'b1;
        b_wa = w; b_we = we; b_long = lng; b_mem = mem; b_div = dv; b_br = br;
    endtask

    task automatic applyStimulus(input string tag, input logic ea, input logic eb);
        exp_t e;
        e.tag = tag;
        e.ia  = ea;
        e.ib  = eb;
        expq.push_back(e);
        exp_dual  += int'(ea & eb);
        exp_stall += int'(a_valid & !ea);
    endtask

    task automatic checkOutput();
        exp_t e;
        @(negedge clk);
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty: observed=no entry expected=one entry");
        end else begin
            e = expq.pop_front();
            checkVal({e.tag, "_issue_a"}, 32'(issue_a), 32'(e.ia));
            checkVal({e.tag, "_issue_b"}, 32'(issue_b), 32'(e.ib));
        end
    endtask

    task automatic step(input string tag, input logic ea, input logic eb);
        applyStimulus(tag, ea, eb);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    initial begin
        setA(0, 1, 2, 3, 1, 0, 0, 0, 0);
        setB(0, 5, 6, 4, 1, 0, 0, 0, 0);
        #12;
        checkVal("reset_issue_a", 32'(issue_a), 32'd0);
        checkVal("reset_busy", busy_mask, 32'd0);
        checkVal("reset_div_busy", 32'(div_busy), 32'd0);
        checkVal("reset_state", 32'(sched_state), 32'd0);
        checkVal("reset_perf_dual", perf_dual, 32'd0);
        checkVal("reset_perf_stall", perf_stall, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // pairing rules
        setA(1, 1, 2, 3, 1, 0, 0, 0, 0); setB(1, 5, 6, 4, 1, 0, 0, 0, 0);
        step("indep_pair", 1, 1);
        checkVal("perf_dual_first", perf_dual, 32'(exp_dual));
        setB(1, 3, 6, 8, 1, 0, 0, 0, 0);
        step("raw_pair", 1, 0);
        setA(1, 3, 6, 8, 1, 0, 0, 0, 0); setB(1, 11, 12, 10, 1, 0, 0, 0, 0);
        step("raw_moved", 1, 1);
        setA(1, 1, 2, 7, 1, 0, 0, 0, 0); setB(1, 5, 6, 7, 1, 0, 0, 0, 0);
        step("waw_pair", 1, 0);
        setA(1, 1, 2, 0, 1, 0, 0, 0, 0); setB(1, 5, 6, 0, 1, 0, 0, 0, 0);
        step("r0_pair", 1, 1);
        setA(1, 1, 2, 3, 1, 0, 1, 0, 0); setB(1, 5, 6, 4, 1, 0, 1, 0, 0);
        step("mem_pair", 1, 0);
        setA(1, 1, 2, 0, 0, 0, 0, 0, 1); setB(1, 5, 6, 4, 1, 0, 0, 0, 0);
        step("br_delay_slot", 1, 1);
        setA(1, 1, 2, 3, 1, 0, 0, 0, 0); setB(1, 5, 6, 0, 0, 0, 0, 0, 1);
        step("b_branch", 1, 0);
        ex_ready = 1'b0;
        setB(1, 5, 6, 4, 1, 0, 0, 0, 0);
        step("not_ready", 0, 0);
        ex_ready = 1'b1;

        // load-use through the scoreboard
        setA(1, 1, 2, 9, 1, 1, 1, 0, 0); setB(0, 5, 6, 4, 1, 0, 0, 0, 0);
        step("load_issue", 1, 0);
        checkVal("busy_after_load", busy_mask, 32'h0000_0200);
        setA(1, 9, 2, 10, 1, 0, 0, 0, 0);
        step("load_use", 0, 0);
        step("load_use_again", 0, 0);
        setA(1, 1, 2, 9, 1, 0, 0, 0, 0);
        step("waw_busy", 0, 0);
        setA(1, 9, 2, 10, 1, 0, 0, 0, 0);
        wb_valid = 1'b1; wb_wa = 5'd9;
        step("wb_cycle", 0, 0);
        wb_valid = 1'b0;
        checkVal("busy_after_wb", busy_mask, 32'd0);
        step("use_after_wb", 1, 0);
        checkVal("perf_stall_load", perf_stall, 32'(exp_stall));
        wb_valid = 1'b1; wb_wa = 5'd9;
        setA(1, 1, 2, 9, 1, 1, 1, 0, 0);
        step("set_over_clear", 1, 0);
        checkVal("busy_set_wins", busy_mask, 32'h0000_0200);
        setA(0, 1, 2, 9, 1, 0, 0, 0, 0);
        step("wb_clear", 0, 0);
        wb_valid = 1'b0;
        checkVal("busy_cleared", busy_mask, 32'd0);

        // divider spacing
        setA(1, 1, 2, 12, 1, 0, 0, 1, 0); setB(1, 5, 6, 13, 1, 0, 0, 1, 0);
        step("div_first_b_div", 1, 0);
        setB(0, 5, 6, 13, 1, 0, 0, 0, 0);
        for (int i = 1; i < 8; i++) begin
            checkVal("div_busy_window", 32'(div_busy), 32'd1);
            step("div_blocked", 0, 0);
        end
        checkVal("div_free", 32'(div_busy), 32'd0);
        step("div_second", 1, 0);
        setA(1, 1, 2, 3, 1, 0, 0, 0, 0); setB(1, 5, 6, 4, 1, 0, 0, 1, 0);
        step("b_div_while_busy", 1, 0);
        setA(0, 1, 2, 3, 1, 0, 0, 0, 0); setB(0, 5, 6, 4, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step("div_drain", 0, 0);
        checkVal("div_drained", 32'(div_busy), 32'd0);

        // flush bubble with a long op in flight
        setA(1, 1, 2, 15, 1, 1, 1, 0, 0);
        step("flush_long", 1, 0);
        checkVal("busy_r15", busy_mask, 32'h0000_8000);
        setA(1, 1, 2, 3, 1, 0, 0, 0, 0);
        flush = 1'b1;
        step("flush_t0", 0, 0);
        flush = 1'b0;
        checkVal("state_flush_t1", 32'(sched_state), 32'd1);
        wb_valid = 1'b1; wb_wa = 5'd15;
        step("flush_t1", 0, 0);
        wb_valid = 1'b0;
        checkVal("state_flush_t2", 32'(sched_state), 32'd1);
        checkVal("busy_wb_in_flush", busy_mask, 32'd0);
        step("flush_t2", 0, 0);
        checkVal("state_run_t3", 32'(sched_state), 32'd0);
        step("flush_t3", 1, 0);
        flush = 1'b1;
        step("reflush_t0", 0, 0);
        step("reflush_t1", 0, 0);
        flush = 1'b0;
        step("reflush_t2", 0, 0);
        step("reflush_t3", 0, 0);
        checkVal("state_after_reflush", 32'(sched_state), 32'd0);
        step("reflush_t4", 1, 0);
        checkVal("perf_dual_total", perf_dual, 32'(exp_dual));
        checkVal("perf_stall_total", perf_stall, 32'(exp_stall));

        // asynchronous reset mid-divide and mid-flush
        setA(1, 1, 2, 20, 1, 1, 1, 0, 0);
        step("pre_rst_long", 1, 0);
        setA(1, 1, 2, 21, 1, 0, 0, 1, 0);
        step("pre_rst_div", 1, 0);
        setA(0, 1, 2, 3, 1, 0, 0, 0, 0);
        flush = 1'b1;
        step("pre_rst_flush", 0, 0);
        flush = 1'b0;
        checkVal("pre_rst_div_busy", 32'(div_busy), 32'd1);
        checkVal("pre_rst_busy", busy_mask, 32'h0010_0000);
        checkVal("pre_rst_state", 32'(sched_state), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        checkVal("rst_div_busy", 32'(div_busy), 32'd0);
        checkVal("rst_busy", busy_mask, 32'd0);
        checkVal("rst_state", 32'(sched_state), 32'd0);
        checkVal("rst_perf_dual", perf_dual, 32'd0);
        checkVal("rst_perf_stall", perf_stall, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
